alu_exec_unit: RTL and testbench

- Execution end of the ALU_CTRL interface: consumes 4-bit ALU_CTRL opcodes from the decoder, with operands, over a valid/ready handshake.
- Returns a registered result plus flags over a second valid/ready handshake to writeback.
- Shifts are iterative, one bit per cycle. The carry flag register persists across operations and feeds ALU_ADDC.

---
 rtl/alu_exec_unit.sv | 158 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : ALU_CTRL execution unit with valid/ready in/out and iterative shifts
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic               zero,
  output logic               illegal
);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_ADDC = 4'd1;
  localparam logic [3:0] c_OP_SUB  = 4'd2;
  localparam logic [3:0] c_OP_SLL  = 4'd3;
  localparam logic [3:0] c_OP_SRA  = 4'd4;
  localparam logic [3:0] c_OP_OR   = 4'd5;
  localparam logic [3:0] c_OP_NEG  = 4'd6;
  localparam logic [3:0] c_OP_AND  = 4'd7;
  localparam logic [3:0] c_OP_GT   = 4'd8;
  localparam logic [3:0] c_OP_LT   = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_illegal;
  logic                 r_sra;
  logic [SHAMT_W-1:0]   r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_bop;
  logic                 w_cin;
  logic [WIDTH-1:0]     w_res;
  logic                 w_carry;
  logic                 w_illegal;
  logic                 w_is_shift;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH-1:0]     w_step;

  assign w_shamt    = b[SHAMT_W-1:0];
  assign w_is_shift = (op == c_OP_SLL) || (op == c_OP_SRA);
  assign w_bop      = (op == c_OP_SUB) ? ~b : b;
  assign w_cin      = (op == c_OP_SUB) | ((op == c_OP_ADDC) & r_carry);
  assign w_sum      = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
  assign w_step     = r_sra ? {r_result[WIDTH-1], r_result[WIDTH-1:1]}
                            : {r_result[WIDTH-2:0], 1'b0};

  // Single-cycle result; shifts only reach here with shamt=0, so they pass a through.
  always_comb begin
    w_res     = '0;
    w_carry   = r_carry;
    w_illegal = 1'b0;
    case (op)
      c_OP_ADD, c_OP_ADDC, c_OP_SUB: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      c_OP_SLL, c_OP_SRA: w_res = a;
      c_OP_OR:            w_res = a | b;
      c_OP_NEG:           w_res = '0 - a;
      c_OP_AND:           w_res = a & b;
      c_OP_GT:            w_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      c_OP_LT:            w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:            w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_sra       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sra     <= (op == c_OP_SRA);
            r_illegal <= w_illegal;
            if (w_is_shift && (w_shamt != '0)) begin
              r_result   <= a;
              r_cnt      <= w_shamt;
              r_in_ready <= 1'b0;
              r_state    <= S_SHIFT;
            end else begin
              r_result    <= w_res;
              r_carry     <= w_carry;
              r_zero      <= (w_res == '0);
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_step;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_zero      <= (w_step == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic       illegal;

  typedef struct {
    logic [7:0] res;
    logic       cy;
    logic       z;
    logic       ill;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_carry  = 1'b0;

  alu_exec_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model; updates the bench's own copy of the carry flag.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] t;
    int sh;
    sh    = int'(y) % 8;
    e.ill = 1'b0;
    e.lat = 1;
    e.res = 8'h00;
    case (o)
      4'd0: begin t = x + y;                 e.res = t[7:0]; m_carry = t[8]; end
      4'd1: begin t = x + y + m_carry;       e.res = t[7:0]; m_carry = t[8]; end
      4'd2: begin t = x + (~y & 8'hFF) + 1;  e.res = t[7:0]; m_carry = t[8]; end
      4'd3: begin e.res = 8'((x << sh) & 8'hFF); e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd4: begin e.res = 8'($signed(x) >>> sh); e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd5: e.res = x | y;
      4'd6: e.res = 8'(256 - int'(x));
      4'd7: e.res = x & y;
      4'd8: e.res = ($signed(x) > $signed(y)) ? 8'h01 : 8'h00;
      4'd9: e.res = ($signed(x) < $signed(y)) ? 8'h01 : 8'h00;
      default: e.ill = 1'b1;
    endcase
    e.cy = m_carry;
    e.z  = (e.res == 8'h00);
    return e;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
    exp_t e;
    int   lat;
    logic [7:0] held;
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL busy_in_ready: got 1, expected 0 at cycle %0d", lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("result", result, e.res);
    check("carry", carry_out, e.cy);
    check("zero", zero, e.z);
    check("illegal", illegal, e.ill);
    held = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'd0; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, held);
      check("hold_carry", carry_out, e.cy);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("ret_in_ready", in_ready, 1);
    check("ret_out_valid", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);

    run_op(4'd0, 8'hF0, 8'h20, 0);
    run_op(4'd1, 8'h01, 8'h01, 0);
    run_op(4'd2, 8'h05, 8'h07, 0);
    run_op(4'd2, 8'h07, 8'h05, 0);
    run_op(4'd6, 8'h01, 8'h33, 0);
    run_op(4'd3, 8'h81, 8'h03, 0);
    run_op(4'd3, 8'h81, 8'h08, 0);
    run_op(4'd4, 8'h90, 8'h02, 0);
    run_op(4'd8, 8'h80, 8'h01, 0);
    run_op(4'd9, 8'h80, 8'h01, 0);
    run_op(4'd0, 8'hFF, 8'h01, 0);
    run_op(4'd7, 8'h0F, 8'h3C, 0);
    run_op(4'd5, 8'h0F, 8'h30, 0);
    run_op(4'd8, 8'h01, 8'hFF, 0);
    run_op(4'hB, 8'h55, 8'hAA, 0);
    run_op(4'd0, 8'h12, 8'h34, 5);

    // Abort an in-flight shift with carry preloaded to 1.
    run_op(4'd0, 8'hFF, 8'h01, 0);
    in_valid = 1'b1; op = 4'd3; a = 8'h01; b = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_carry = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_carry", carry_out, 0);
    check("abort_result", result, 0);

    for (int k = 0; k < 24; k++)
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
